// File: rtl/mfb_frame_stats_pkg.sv
// Shared types and helpers for the MFB frame statistics block.
package mfb_frame_stats_pkg;

  typedef enum logic {
    WRAP     = 1'b0,
    SATURATE = 1'b1
  } cnt_mode_t;

  // Upper bound on regions handled by popcount; wider words need a bigger vector.
  localparam int MAX_REGIONS = 64;

  function automatic int unsigned popcount(input logic [MAX_REGIONS-1:0] v);
    popcount = 0;
    for (int i = 0; i < MAX_REGIONS; i++) begin
      popcount += 32'(v[i]);
    end
  endfunction

endpackage

// File: rtl/mfb_frame_stats_cnt.sv
// One frame counter: adds a registered increment, optional clear, wrap or clamp on overflow.
module mfb_frame_stats_cnt
  import mfb_frame_stats_pkg::*;
#(
  parameter int        CNT_WIDTH = 32,
  parameter int        INC_W     = 1,
  parameter cnt_mode_t CNT_MODE  = WRAP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INC_W-1:0]     i_inc,
  input  logic                 i_clr,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_ovf
);

  localparam int SUM_W = CNT_WIDTH + 1;

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;
  logic [CNT_WIDTH-1:0] w_base;
  logic [SUM_W-1:0]     w_sum;
  logic [CNT_WIDTH-1:0] w_next;

  // A clear restarts from zero but still takes the increment landing this edge.
  assign w_base = i_clr ? '0 : r_cnt;
  assign w_sum  = {1'b0, w_base} + SUM_W'(i_inc);

  always_comb begin
    w_next = w_sum[CNT_WIDTH-1:0];
    if (w_sum[CNT_WIDTH] && (CNT_MODE == SATURATE)) begin
      w_next = '1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_next;
      r_ovf <= (r_ovf & ~i_clr) | w_sum[CNT_WIDTH];
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/mfb_frame_stats.sv
// Passive MFB monitor: counts ending frames per channel, read port with optional clear.
module mfb_frame_stats
  import mfb_frame_stats_pkg::*;
#(
  parameter int        REGIONS    = 1,
  parameter int        CHANNELS   = 4,
  parameter int        CNT_WIDTH  = 32,
  parameter cnt_mode_t CNT_MODE   = WRAP,
  parameter bit        OUTPUT_REG = 1'b1,
  // One spare code beyond the channel range so out-of-range requests are expressible.
  localparam int       CH_W       = $clog2(CHANNELS + 1)
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [REGIONS-1:0]      RX_EOF,
  input  logic [REGIONS*CH_W-1:0] RX_CHAN,
  input  logic                    RX_SRC_RDY,
  input  logic                    RX_DST_RDY,
  input  logic                    RD_EN,
  input  logic                    RD_CLR,
  input  logic [CH_W-1:0]         RD_CHAN,
  output logic [CNT_WIDTH-1:0]    RD_DATA,
  output logic                    RD_OVF,
  output logic                    RD_VLD
);

  localparam int INC_W = $clog2(REGIONS + 1);

  logic                 w_accept;
  logic [REGIONS-1:0]   w_hit [CHANNELS];
  logic [INC_W-1:0]     w_inc [CHANNELS];
  logic [INC_W-1:0]     r_inc [CHANNELS];
  logic [CHANNELS-1:0]  w_clr;
  logic [CNT_WIDTH-1:0] w_cnt [CHANNELS];
  logic [CHANNELS-1:0]  w_ovf;
  logic [CNT_WIDTH-1:0] w_rd_data;
  logic                 w_rd_ovf;
  logic                 r_s1_vld;
  logic [CNT_WIDTH-1:0] r_s1_data;
  logic                 r_s1_ovf;

  assign w_accept = RX_SRC_RDY & RX_DST_RDY;

  // NOTE: defaults at the top of always_comb keep every path assigned, so no latches.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_hit[c] = '0;
      for (int r = 0; r < REGIONS; r++) begin
        w_hit[c][r] = w_accept & RX_EOF[r] & (RX_CHAN[r*CH_W +: CH_W] == CH_W'(c));
      end
      w_inc[c] = INC_W'(popcount(MAX_REGIONS'(w_hit[c])));
    end
  end

  // NOTE: the inc array is a few flops, not a RAM, so it takes the async reset like any register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int c = 0; c < CHANNELS; c++) r_inc[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) r_inc[c] <= w_inc[c];
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign w_clr[c] = RD_EN & RD_CLR & (RD_CHAN == CH_W'(c));

    mfb_frame_stats_cnt #(
      .CNT_WIDTH (CNT_WIDTH),
      .INC_W     (INC_W),
      .CNT_MODE  (CNT_MODE)
    ) u_cnt (
      .clk   (CLK),
      .rst_n (RESET_N),
      .i_inc (r_inc[c]),
      .i_clr (w_clr[c]),
      .o_cnt (w_cnt[c]),
      .o_ovf (w_ovf[c])
    );
  end

  // Out-of-range channels match nothing and read back as zero.
  always_comb begin
    w_rd_data = '0;
    w_rd_ovf  = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (RD_CHAN == CH_W'(c)) begin
        w_rd_data = w_cnt[c];
        w_rd_ovf  = w_ovf[c];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
      r_s1_ovf  <= 1'b0;
    end else begin
      r_s1_vld <= RD_EN;
      if (RD_EN) begin
        r_s1_data <= w_rd_data;
        r_s1_ovf  <= w_rd_ovf;
      end
    end
  end

  if (OUTPUT_REG) begin : g_oreg
    logic                 r_s2_vld;
    logic [CNT_WIDTH-1:0] r_s2_data;
    logic                 r_s2_ovf;

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        r_s2_vld  <= 1'b0;
        r_s2_data <= '0;
        r_s2_ovf  <= 1'b0;
      end else begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_data <= r_s1_data;
          r_s2_ovf  <= r_s1_ovf;
        end
      end
    end

    assign RD_VLD  = r_s2_vld;
    assign RD_DATA = r_s2_data;
    assign RD_OVF  = r_s2_ovf;
  end else begin : g_noreg
    assign RD_VLD  = r_s1_vld;
    assign RD_DATA = r_s1_data;
    assign RD_OVF  = r_s1_ovf;
  end

endmodule
